// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: datapath width,
// default reset PC, fetch FSM encoding and the PC increment helper.
package if_pkg;

  localparam int unsigned XLEN = 16;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 16'h0000;
  localparam logic [XLEN-1:0] PC_STEP = 16'h0002;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_REDIR = 2'b10
  } fetch_state_e;

  // Sequential PC: next halfword, wrapping modulo 2^16.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: clear > stall (hold) > load; with
// none of them asserted the entry becomes a bubble and the fields hold.
module if_id_reg
  import if_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            stall_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pc_plus2_i,
  input  logic [XLEN-1:0] instr_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus2_o,
  output logic [XLEN-1:0] instr_o,
  output logic            valid_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus2_q, pc_plus2_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            valid_q, valid_d;

  // Next-state selection for the entry fields and its valid bit.
  always_comb begin
    pc_d       = pc_q;
    pc_plus2_d = pc_plus2_q;
    instr_d    = instr_q;
    valid_d    = 1'b0;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (stall_i) begin
      valid_d = valid_q;
    end else if (load_i) begin
      pc_d       = pc_i;
      pc_plus2_d = pc_plus2_i;
      instr_d    = instr_i;
      valid_d    = 1'b1;
    end else begin
      valid_d = 1'b0;
    end
  end

  // Entry storage with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= 16'h0000;
      pc_plus2_q <= 16'h0000;
      instr_q    <= 16'h0000;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_plus2_q <= pc_plus2_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_plus2_o = pc_plus2_q;
  assign instr_o    = instr_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, fetch FSM, instruction-memory
// request/ready handshake and the IF/ID register.
// Optional feature macro IF_FETCH_CNT_EN adds the fetch_cnt transfer counter.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_next,
  input  logic            redirect,
  input  logic            stall,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pc_plus2,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_pc_plus2,
  output logic [XLEN-1:0] ifid_instr,
`ifdef IF_FETCH_CNT_EN
  output logic [XLEN-1:0] fetch_cnt,
`endif
  output logic            ifid_valid
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            fetch_req;
  logic            redir_act;
  logic            xfer;

  // A redirect only counts once the FSM has left IDLE after reset.
  assign redir_act = redirect && (state_q != ST_IDLE);
  // Gated by rst_n so no request is seen while reset is being applied,
  // which also aborts any handshake that was pending.
  assign imem_req  = rst_n && fetch_req;
  assign xfer      = imem_req && imem_ready;
  assign imem_addr = pc_q;
  assign pc_plus2  = pc_inc(pc_q);

  // Fetch FSM next state and request decode. A redirect seen while already
  // in REDIR re-enters REDIR so the new target also gets its dead cycle.
  always_comb begin
    state_d   = state_q;
    fetch_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        fetch_req = !stall && !flush && !redirect;
        state_d   = redirect ? ST_REDIR : ST_FETCH;
      end
      ST_REDIR: begin
        state_d = redirect ? ST_REDIR : ST_FETCH;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // PC update: redirect target, or the selected next PC after a transfer.
  always_comb begin
    pc_d = pc_q;
    if (redir_act) begin
      pc_d = pc_next;
    end else if (xfer) begin
      pc_d = pc_next;
    end else begin
      pc_d = pc_q;
    end
  end

  // State and PC registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (xfer),
    .stall_i    (stall),
    .clear_i    (redir_act || flush),
    .pc_i       (pc_q),
    .pc_plus2_i (pc_plus2),
    .instr_i    (imem_rdata),
    .pc_o       (ifid_pc),
    .pc_plus2_o (ifid_pc_plus2),
    .instr_o    (ifid_instr),
    .valid_o    (ifid_valid)
  );

`ifdef IF_FETCH_CNT_EN
  logic [XLEN-1:0] cnt_q, cnt_d;

  // Transfer counter next value, wrapping modulo 2^16.
  always_comb begin
    cnt_d = cnt_q;
    if (xfer) begin
      cnt_d = cnt_q + 16'h0001;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Transfer counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 16'h0000;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fetch_cnt = cnt_q;
`endif

endmodule
